// File: rtl/video_sync_v_gen.sv
// rtl/video_sync_v_gen.sv - vertical timing generator: line counter, vblank/vsync/vpix, INT strobe, frame counter
// Mode inputs are latched at the frame wrap so that period and window stay stable for a whole frame.
module video_sync_v_gen #(
    parameter int VCW           = 9,
    parameter int VPERIOD_50    = 320,
    parameter int VPERIOD_60    = 264,
    parameter int VBLNK_BEG     = 0,
    parameter int VSYNC_BEG     = 8,
    parameter int VSYNC_END     = 11,
    parameter int VBLNK_END     = 32,
    parameter int INT_LINE      = 0,
    parameter int VPIX_BEG_PENT = 80,
    parameter int VPIX_END_PENT = 272,
    parameter int VPIX_BEG_ATM  = 76,
    parameter int VPIX_END_ATM  = 276,
    parameter int VPIX_SHIFT_60 = 32,
    parameter int FCW           = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hsync_start,
    input  logic           line_start,
    input  logic           hint_start,
    input  logic           mode_atm_n_pent,
    input  logic           mode_60hz,
    output logic           vblank,
    output logic           vsync,
    output logic           int_start,
    output logic           vpix,
    output logic           frame_start,
    output logic [VCW-1:0] vcount,
    output logic [FCW-1:0] frame_cnt
);

    localparam logic [VCW-1:0] LAST_50       = VCW'(VPERIOD_50 - 1);
    localparam logic [VCW-1:0] LAST_60       = VCW'(VPERIOD_60 - 1);
    localparam logic [VCW-1:0] L_VBLNK_BEG   = VCW'(VBLNK_BEG);
    localparam logic [VCW-1:0] L_VBLNK_END   = VCW'(VBLNK_END);
    localparam logic [VCW-1:0] L_VSYNC_BEG   = VCW'(VSYNC_BEG);
    localparam logic [VCW-1:0] L_VSYNC_END   = VCW'(VSYNC_END);
    localparam logic [VCW-1:0] L_INT_LINE    = VCW'(INT_LINE);
    localparam logic [VCW-1:0] PENT_BEG_50   = VCW'(VPIX_BEG_PENT);
    localparam logic [VCW-1:0] PENT_END_50   = VCW'(VPIX_END_PENT);
    localparam logic [VCW-1:0] ATM_BEG_50    = VCW'(VPIX_BEG_ATM);
    localparam logic [VCW-1:0] ATM_END_50    = VCW'(VPIX_END_ATM);
    localparam logic [VCW-1:0] PENT_BEG_60   = VCW'(VPIX_BEG_PENT - VPIX_SHIFT_60);
    localparam logic [VCW-1:0] PENT_END_60   = VCW'(VPIX_END_PENT - VPIX_SHIFT_60);
    localparam logic [VCW-1:0] ATM_BEG_60    = VCW'(VPIX_BEG_ATM - VPIX_SHIFT_60);
    localparam logic [VCW-1:0] ATM_END_60    = VCW'(VPIX_END_ATM - VPIX_SHIFT_60);

    // Parameter sanity: the ordering of events within a frame must hold in every mode.
    if (!(VBLNK_BEG < VSYNC_BEG && VSYNC_BEG < VSYNC_END && VSYNC_END < VBLNK_END)) begin : g_bad_sync_order
        $error("video_sync_v_gen: blank/sync lines out of order");
    end
    if (!(VPIX_SHIFT_60 >= 0 &&
          VBLNK_END < VPIX_BEG_PENT - VPIX_SHIFT_60 && VBLNK_END < VPIX_BEG_ATM - VPIX_SHIFT_60 &&
          VBLNK_END < VPIX_BEG_PENT && VBLNK_END < VPIX_BEG_ATM)) begin : g_bad_pix_beg
        $error("video_sync_v_gen: picture window begins inside vblank");
    end
    if (!(VPIX_BEG_PENT < VPIX_END_PENT && VPIX_BEG_ATM < VPIX_END_ATM &&
          VPIX_END_PENT < VPERIOD_50 && VPIX_END_ATM < VPERIOD_50 &&
          VPIX_END_PENT - VPIX_SHIFT_60 < VPERIOD_60 &&
          VPIX_END_ATM - VPIX_SHIFT_60 < VPERIOD_60)) begin : g_bad_pix_end
        $error("video_sync_v_gen: picture window end out of range");
    end
    if (!(VPERIOD_50 <= (1 << VCW) && VPERIOD_60 <= (1 << VCW) && VPERIOD_50 > 0 && VPERIOD_60 > 0)) begin : g_bad_period
        $error("video_sync_v_gen: period does not fit the line counter");
    end

    logic [VCW-1:0] vcount_q, vcount_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           atm_q, atm_d;
    logic           m60_q, m60_d;
    logic           vblank_q, vblank_d;
    logic           vsync_q, vsync_d;
    logic           int_start_q, int_start_d;
    logic           vpix_q, vpix_d;
    logic           frame_start_q, frame_start_d;

    logic [VCW-1:0] period_last;
    logic [VCW-1:0] pix_beg;
    logic [VCW-1:0] pix_end;
    logic           wrap;

    always_comb begin
        period_last = m60_q ? LAST_60 : LAST_50;
        if (atm_q) begin
            pix_beg = m60_q ? ATM_BEG_60 : ATM_BEG_50;
            pix_end = m60_q ? ATM_END_60 : ATM_END_50;
        end else begin
            pix_beg = m60_q ? PENT_BEG_60 : PENT_BEG_50;
            pix_end = m60_q ? PENT_END_60 : PENT_END_50;
        end
        wrap = hsync_start && (vcount_q == period_last);
    end

    // All comparisons below look at the line number held before this cycle's update.
    always_comb begin
        vcount_d      = vcount_q;
        frame_cnt_d   = frame_cnt_q;
        atm_d         = atm_q;
        m60_d         = m60_q;
        vblank_d      = vblank_q;
        vsync_d       = vsync_q;
        vpix_d        = vpix_q;
        int_start_d   = hint_start && (vcount_q == L_INT_LINE);
        frame_start_d = wrap;

        if (hsync_start) begin
            if (wrap) begin
                vcount_d    = '0;
                frame_cnt_d = frame_cnt_q + FCW'(1);
                atm_d       = mode_atm_n_pent;
                m60_d       = mode_60hz;
            end else begin
                vcount_d = vcount_q + VCW'(1);
            end

            if (vcount_q == L_VBLNK_BEG) begin
                vblank_d = 1'b1;
            end else if (vcount_q == L_VBLNK_END) begin
                vblank_d = 1'b0;
            end

            if (vcount_q == pix_beg) begin
                vpix_d = 1'b1;
            end else if (vcount_q == pix_end) begin
                vpix_d = 1'b0;
            end
        end

        if (hsync_start && (vcount_q == L_VSYNC_BEG)) begin
            vsync_d = 1'b1;
        end else if (line_start && (vcount_q == L_VSYNC_END)) begin
            vsync_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vcount_q      <= '0;
            frame_cnt_q   <= '0;
            atm_q         <= 1'b0;
            m60_q         <= 1'b0;
            vblank_q      <= 1'b0;
            vsync_q       <= 1'b0;
            int_start_q   <= 1'b0;
            vpix_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vcount_q      <= vcount_d;
            frame_cnt_q   <= frame_cnt_d;
            atm_q         <= atm_d;
            m60_q         <= m60_d;
            vblank_q      <= vblank_d;
            vsync_q       <= vsync_d;
            int_start_q   <= int_start_d;
            vpix_q        <= vpix_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vcount      = vcount_q;
    assign frame_cnt   = frame_cnt_q;
    assign vblank      = vblank_q;
    assign vsync       = vsync_q;
    assign int_start   = int_start_q;
    assign vpix        = vpix_q;
    assign frame_start = frame_start_q;

endmodule
